// File: rtl/vflag_pkg.sv
// Shared constants and slice helpers for the vector flag read-bypass stage.
package vflag_pkg;

  localparam int unsigned NUMLANES_DEF    = 2;
  localparam int unsigned WIDTH_DEF       = 4;
  localparam int unsigned LOG2NUMREGS_DEF = 9;
  localparam int unsigned CNTW_DEF        = 16;

  // LSB of lane `lane` inside a packed per-lane bus whose slices are `w` bits wide.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/vflag_bypass_lane.sv
// One read port of one lane: captures same-cycle write hits and muxes the
// written flags over the regfile's stale output on the following cycle.
module vflag_bypass_lane
  import vflag_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned LOG2NUMREGS = LOG2NUMREGS_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [LOG2NUMREGS-1:0] rd_reg,
  input  logic                   rd_en,
  input  logic [LOG2NUMREGS-1:0] wr_reg,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       rf_data,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid,
  output logic                   hit_pulse
);

  logic             hit_q, hit_d;
  logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic             valid_q;

  // wr_en gates the compare so undriven addresses never leak X into hit.
  always_comb begin
    hit_pulse  = rd_en && wr_en && (wr_reg == rd_reg);
    hit_d      = hit_q;
    fwd_data_d = fwd_data_q;
    if (rd_en) begin
      hit_d      = wr_en && (wr_reg == rd_reg);
      fwd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      hit_q      <= 1'b0;
      fwd_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      fwd_data_q <= fwd_data_d;
      valid_q    <= rd_en;
    end
  end

  always_comb begin
    data_out = hit_q ? fwd_data_q : rf_data;
    valid    = valid_q;
  end

endmodule

// File: rtl/vflag_read_bypass.sv
// Read-after-write bypass for both flag read ports of every lane, with
// saturating counters of how many reads were served from the bypass.
module vflag_read_bypass
  import vflag_pkg::*;
#(
  parameter int unsigned NUMLANES    = NUMLANES_DEF,
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned LOG2NUMREGS = LOG2NUMREGS_DEF,
  parameter int unsigned CNTW        = CNTW_DEF
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUMLANES*LOG2NUMREGS-1:0] a_reg,
  input  logic [NUMLANES-1:0]             a_en,
  input  logic [NUMLANES*LOG2NUMREGS-1:0] b_reg,
  input  logic [NUMLANES-1:0]             b_en,
  input  logic [NUMLANES*LOG2NUMREGS-1:0] c_reg,
  input  logic [NUMLANES*WIDTH-1:0]       c_writedatain,
  input  logic [NUMLANES-1:0]             c_we,
  input  logic [NUMLANES*WIDTH-1:0]       rf_a_readdata,
  input  logic [NUMLANES*WIDTH-1:0]       rf_b_readdata,
  output logic [NUMLANES*WIDTH-1:0]       a_readdataout,
  output logic [NUMLANES*WIDTH-1:0]       b_readdataout,
  output logic [NUMLANES-1:0]             a_valid,
  output logic [NUMLANES-1:0]             b_valid,
  output logic [CNTW-1:0]                 a_fwd_count,
  output logic [CNTW-1:0]                 b_fwd_count
);

  localparam int unsigned     SumW   = CNTW + $clog2(NUMLANES + 1);
  localparam logic [CNTW-1:0] CntMax = '1;

  logic [NUMLANES-1:0] a_hit, b_hit;
  logic [CNTW-1:0]     a_cnt_q, a_cnt_d;
  logic [CNTW-1:0]     b_cnt_q, b_cnt_d;

  for (genvar l = 0; l < NUMLANES; l++) begin : g_lane
    localparam int unsigned AddrLsb = lane_lsb(l, LOG2NUMREGS);
    localparam int unsigned DataLsb = lane_lsb(l, WIDTH);

    vflag_bypass_lane #(
      .WIDTH       (WIDTH),
      .LOG2NUMREGS (LOG2NUMREGS)
    ) u_port_a (
      .clk       (clk),
      .resetn    (resetn),
      .rd_reg    (a_reg[AddrLsb +: LOG2NUMREGS]),
      .rd_en     (a_en[l]),
      .wr_reg    (c_reg[AddrLsb +: LOG2NUMREGS]),
      .wr_data   (c_writedatain[DataLsb +: WIDTH]),
      .wr_en     (c_we[l]),
      .rf_data   (rf_a_readdata[DataLsb +: WIDTH]),
      .data_out  (a_readdataout[DataLsb +: WIDTH]),
      .valid     (a_valid[l]),
      .hit_pulse (a_hit[l])
    );

    vflag_bypass_lane #(
      .WIDTH       (WIDTH),
      .LOG2NUMREGS (LOG2NUMREGS)
    ) u_port_b (
      .clk       (clk),
      .resetn    (resetn),
      .rd_reg    (b_reg[AddrLsb +: LOG2NUMREGS]),
      .rd_en     (b_en[l]),
      .wr_reg    (c_reg[AddrLsb +: LOG2NUMREGS]),
      .wr_data   (c_writedatain[DataLsb +: WIDTH]),
      .wr_en     (c_we[l]),
      .rf_data   (rf_b_readdata[DataLsb +: WIDTH]),
      .data_out  (b_readdataout[DataLsb +: WIDTH]),
      .valid     (b_valid[l]),
      .hit_pulse (b_hit[l])
    );
  end

  // Sum in a wider accumulator so several lanes hitting at the top cannot wrap.
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0]     cnt,
                                              input logic [NUMLANES-1:0] hits);
    logic [SumW-1:0] sum;
    sum = SumW'(cnt);
    for (int l = 0; l < NUMLANES; l++) begin
      sum = sum + SumW'(hits[l]);
    end
    return (sum > SumW'(CntMax)) ? CntMax : sum[CNTW-1:0];
  endfunction

  always_comb begin
    a_cnt_d = sat_add(a_cnt_q, a_hit);
    b_cnt_d = sat_add(b_cnt_q, b_hit);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  always_comb begin
    a_fwd_count = a_cnt_q;
    b_fwd_count = b_cnt_q;
  end

endmodule

// File: doc/vflag_read_bypass.md
Name: vflag_read_bypass

Overview:
- Per-lane read-after-write bypass stage on the read side of the vector flag register file.
- The flag register file has a 1-cycle synchronous read and returns OLD data when a read and a write hit the same address in the same cycle.
- This block snoops the writeback port, registers same-cycle hits, and muxes the freshly written flags onto read ports a and b one cycle later.
- Sits between the flag register file outputs and the vector lane flag consumers (predication/masking logic).

Parameters:
NUMLANES, 2, number of vector lanes (independent per-lane flag banks)
WIDTH, 4, flag bits per lane per register entry
LOG2NUMREGS, 9, flag register address width per lane
CNTW, 16, width of each saturating forward-hit counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-high (1 = reset), one clock domain
a_reg  in  NUMLANES*LOG2NUMREGS  port-a read address per lane (same value driven to regfile)
a_en  in  NUMLANES  port-a read enable per lane
b_reg  in  NUMLANES*LOG2NUMREGS  port-b read address per lane
b_en  in  NUMLANES  port-b read enable per lane
c_reg  in  NUMLANES*LOG2NUMREGS  write address per lane (same as regfile)
c_writedatain  in  NUMLANES*WIDTH  write data per lane
c_we  in  NUMLANES  write enable per lane
rf_a_readdata  in  NUMLANES*WIDTH  regfile port-a output (valid cycle after a_en)
rf_b_readdata  in  NUMLANES*WIDTH  regfile port-b output
a_readdataout  out  NUMLANES*WIDTH  bypassed port-a flags
b_readdataout  out  NUMLANES*WIDTH  bypassed port-b flags
a_valid  out  NUMLANES  a_en delayed one cycle
b_valid  out  NUMLANES  b_en delayed one cycle
a_fwd_count  out  CNTW  saturating count of port-a forwards, all lanes summed
b_fwd_count  out  CNTW  saturating count of port-b forwards, all lanes summed

Behaviour:
- All state is per (lane, port). Lanes are fully independent; no cross-lane comparison.
- State per (lane, port): hit (1b), fwd_data (WIDTH), valid (1b).
- Cycle T with en[l]=1:
  - hit <= c_we[l] && (c_reg[l] == rd_reg[l]).
  - fwd_data <= c_writedatain[l].
  - valid <= 1.
- Cycle T with en[l]=0:
  - hit and fwd_data HOLD, matching the regfile output, which holds when rden=0.
  - valid <= 0.
- Output at T+1 (combinational mux, no added latency): readdataout[l] = hit ? fwd_data : rf_readdata[l]. Total latency is 1 cycle from address to data, identical to a bare regfile.
- A write at T+1 to the address read at T is NOT forwarded: the read was architecturally ordered before it.
- Back-to-back reads of one address with a write in the first cycle: the first read is forwarded; the second read (issued T+1) gets correct data from the RAM.
- c_we=1 with en=0 in the same cycle: no state change except valid <= 0.
- Counters:
  - Per cycle, a_fwd_count += popcount over lanes of (a_en & c_we & addr_match); b likewise.
  - Saturate at 2^CNTW-1 and never wrap.
- Reset (resetn=1 at a clk edge): hit=0, fwd_data=0, valid=0, counters=0. Outputs then pass rf data through.
- Reset mid-operation: in-flight forwards are discarded. The cycle after reset deassertion behaves as a fresh start.
- No X propagation: the compare is gated by c_we; addresses may be X when c_we=0 and en=0.

Decomposition:
- Shared package (vflag_pkg): constants for NUMLANES, WIDTH, LOG2NUMREGS defaults, plus the lane slice helper width localparams.
- One natural sub-module, vflag_bypass_lane:
  - One read port of one lane.
  - Holds hit/fwd_data/valid and the mux; emits a hit-pulse.
  - Instantiated 2*NUMLANES times.
- Top level sums the hit-pulses into the two saturating counters.

Test Plan:
- No hazard, lane0: write reg 5=0xA at T0; a_reg=5, a_en=1 at T1 -> at T2 a_readdataout[3:0]=rf data (0xA), a_valid[0]=1, a_fwd_count=0.
- Same-cycle hazard, lane1: c_reg=7, c_we=1, data=0x3 while b_reg=7, b_en=1; rf returns old 0xC -> next cycle b_readdataout[7:4]=0x3, b_fwd_count=1.
- Hold: after a forwarded read of 0x3 on port a, drive a_en=0 for 3 cycles while writing other values -> a_readdataout stays 0x3, a_valid=0.
- Late write: read reg 9 at T, write reg 9=0xF at T+1 -> T+1 output is RAM old value, not 0xF; count unchanged.
- Lane isolation: lane0 writes reg 4 while lane1 reads reg 4 -> lane1 not forwarded.
- Saturation/reset: with CNTW=4, force 20 port-a hits -> count holds at 15; assert resetn=1 one cycle -> count=0, valid=0, outputs equal rf data.
